// File: rtl/lsu_pkg.sv
// Shared types and helpers for the dmem load/store unit.
package lsu_pkg;

    localparam int DMEM_IDX_W = 10;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HALF  = 2'b01,
        WORD  = 2'b10,
        DWORD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RMW  = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return off[0];
            WORD:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    // Natural alignment: clear the offset bits below the access size.
    function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
        case (size)
            BYTE:    return off;
            HALF:    return {off[2:1], 1'b0};
            WORD:    return {off[2], 2'b00};
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic for dmem_lsu: byte mask, store merge and load extract/extend.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] mem_dout,
    output logic [63:0] merged,
    output logic [63:0] load_data
);

    logic [7:0]  byte_mask;
    logic [63:0] bit_mask;
    logic [63:0] wdata_sh;
    logic [63:0] dout_sh;
    logic [5:0]  shamt;

    always_comb begin
        shamt = {offset, 3'b000};
        case (size)
            BYTE:    byte_mask = 8'h01 << offset;
            HALF:    byte_mask = 8'h03 << offset;
            WORD:    byte_mask = 8'h0F << offset;
            default: byte_mask = 8'hFF;
        endcase
        bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
        wdata_sh = wdata << shamt;
        merged   = (mem_dout & ~bit_mask) | (wdata_sh & bit_mask);
    end

    always_comb begin
        dout_sh = mem_dout >> shamt;
        case (size)
            BYTE:    load_data = is_unsigned ? {56'b0, dout_sh[7:0]}
                                             : {{56{dout_sh[7]}}, dout_sh[7:0]};
            HALF:    load_data = is_unsigned ? {48'b0, dout_sh[15:0]}
                                             : {{48{dout_sh[15]}}, dout_sh[15:0]};
            WORD:    load_data = is_unsigned ? {32'b0, dout_sh[31:0]}
                                             : {{32{dout_sh[31]}}, dout_sh[31:0]};
            default: load_data = dout_sh;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of dmem; sub-dword stores use read-modify-write.
// Optional macro LSU_MISALIGN_CHECK_EN enables misalignment errors instead of forced alignment.
//
// state | meaning
// IDLE  | ready; an accepted request issues its first memory access
// LOAD  | read data returns; extended load data is presented
// RMW   | read data returns; merged word is written back
// RESP  | dword store or misaligned request completes
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [9:0]        mem_addr,
    output logic [63:0]       mem_din,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [63:0]       mem_dout
);

    lsu_state_e            state, state_nxt;
    logic [DMEM_IDX_W-1:0] idx_q;
    logic [2:0]            off_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  err_q;
    logic [63:0]           wdata_q;

    logic                  accept;
    logic                  req_mis;
    logic [2:0]            req_off;
    logic [DMEM_IDX_W-1:0] req_idx;
    logic [63:0]           merged;
    logic [63:0]           load_data;

    assign req_idx = DMEM_IDX_W'(req_addr[ADDR_W-1:3]);

`ifdef LSU_MISALIGN_CHECK_EN
    assign req_mis = misaligned(req_size, req_addr[2:0]);
    assign req_off = req_addr[2:0];
`else
    assign req_mis = 1'b0;
    assign req_off = align_off(req_size, req_addr[2:0]);
`endif

    lsu_lane u_lane (
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .mem_dout    (mem_dout),
        .merged      (merged),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state   <= IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx_q   <= req_idx;
                off_q   <= req_off;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                err_q   <= req_mis;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_din   = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        req_ready = (state == IDLE) && reset_b;
        accept    = req_valid && req_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_mis) begin
                        state_nxt = RESP;
                    end else if (!req_we) begin
                        mem_read  = 1'b1;
                        mem_addr  = req_idx;
                        state_nxt = LOAD;
                    end else if (req_size == DWORD) begin
                        mem_write = 1'b1;
                        mem_addr  = req_idx;
                        mem_din   = req_wdata;
                        state_nxt = RESP;
                    end else begin
                        mem_read  = 1'b1;
                        mem_addr  = req_idx;
                        state_nxt = RMW;
                    end
                end
            end
            LOAD: begin
                rsp_valid = 1'b1;
                rsp_rdata = load_data;
                state_nxt = IDLE;
            end
            RMW: begin
                rsp_valid = 1'b1;
                mem_write = 1'b1;
                mem_addr  = idx_q;
                mem_din   = merged;
                state_nxt = IDLE;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A reset cycle issues nothing and drops any pending write or response.
        if (!reset_b) begin
            mem_addr  = '0;
            mem_din   = '0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            rsp_valid = 1'b0;
            rsp_rdata = '0;
            rsp_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized scoreboard bench for dmem_lsu with a byte-level memory reference model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [12:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    logic [63:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_dout = '0;

    dmem_lsu #(.ADDR_W(13)) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_dout     (mem_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dmem stand-in: synchronous read, data valid the cycle after mem_read
    logic [63:0] dmem [1024];
    logic [63:0] ref_mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = '0;
            ref_mem[i] = '0;
        end
    end
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr] <= mem_din;
        if (mem_read)  mem_dout <= dmem[mem_addr];
    end

    typedef struct {
        int          cyc;
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: byte-level view of memory; response is due the cycle after acceptance.
    task automatic model_accept(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [12:0] addr, input logic [63:0] wd, input int acc,
                                output logic mis, output int idx);
        int nb;
        int off;
        logic [63:0] val;
        exp_t e;
        nb  = 1 << sz;
        idx = int'(addr) / 8;
        off = int'(addr) % 8;
        mis = (off % nb) != 0;
`ifndef LSU_MISALIGN_CHECK_EN
        off = off - (off % nb);
        mis = 1'b0;
`endif
        val = '0;
        e.cyc = acc + 1;
        if (mis) begin
            e.rdata = '0;
            e.err   = 1'b1;
        end else if (!we) begin
            for (int b = 0; b < nb; b++) val[8*b +: 8] = ref_mem[idx][8*(off+b) +: 8];
            if (!uns && nb < 8 && val[8*nb-1])
                for (int b = nb; b < 8; b++) val[8*b +: 8] = 8'hFF;
            e.rdata = val;
            e.err   = 1'b0;
        end else begin
            for (int b = 0; b < nb; b++) ref_mem[idx][8*(off+b) +: 8] = wd[8*b +: 8];
            e.rdata = '0;
            e.err   = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [12:0] addr, input logic [63:0] wd, input logic hold,
                         output int acc);
        logic mis;
        int idx;
        int waited;
        logic sub_st;
        waited = 0;
        acc = -1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        #1;
        while (!req_ready && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: req_ready got 0, required 1");
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        model_accept(we, sz, uns, addr, wd, acc, mis, idx);
        sub_st = !mis && we && sz != 2'd3;
        chk("acc_mem_read",  64'(mem_read),  64'(!mis && (!we || sz != 2'd3)));
        chk("acc_mem_write", 64'(mem_write), 64'(!mis && we && sz == 2'd3));
        if (!mis) chk("acc_mem_addr", 64'(mem_addr), 64'(idx));
        if (!mis && we && sz == 2'd3) chk("acc_mem_din", mem_din, wd);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        @(negedge clk); #1;
        chk("busy_req_ready", 64'(req_ready), 64'(0));
        chk("n1_mem_read",    64'(mem_read),  64'(0));
        chk("n1_mem_write",   64'(mem_write), 64'(sub_st));
        if (sub_st) begin
            chk("rmw_mem_addr", 64'(mem_addr), 64'(idx));
            chk("rmw_mem_din",  mem_din, ref_mem[idx]);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (mem_read || mem_write) chk("rd_wr_exclusive", 64'(mem_read && mem_write), 64'(0));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1, required 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err",   64'(rsp_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int accs[4];
        logic [12:0] a;
        logic [1:0] sz;

        @(negedge clk); #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", rsp_rdata, 64'(0));
        chk("rst_rsp_err",   64'(rsp_err), 64'(0));
        chk("rst_mem_rw",    64'({mem_read, mem_write}), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_ready", 64'(req_ready), 64'(1));

        issue(1'b1, 2'd3, 1'b0, 13'h010, 64'h0123_4567_89AB_CDEF, 1'b0, acc);
        issue(1'b0, 2'd3, 1'b0, 13'h010, 64'h0, 1'b0, acc);
        issue(1'b1, 2'd0, 1'b0, 13'h013, 64'hFF, 1'b0, acc);
        @(negedge clk);
        chk("plan_rmw_word", dmem[2], 64'h0123_4567_FFAB_CDEF);
        issue(1'b0, 2'd0, 1'b0, 13'h013, 64'h0, 1'b0, acc);
        issue(1'b0, 2'd1, 1'b1, 13'h012, 64'h0, 1'b0, acc);
        issue(1'b0, 2'd2, 1'b0, 13'h016, 64'h0, 1'b0, acc);

        issue(1'b0, 2'd3, 1'b0, 13'h010, 64'h0, 1'b1, accs[0]);
        issue(1'b1, 2'd1, 1'b0, 13'h01A, 64'hBEEF, 1'b1, accs[1]);
        issue(1'b0, 2'd2, 1'b1, 13'h018, 64'h0, 1'b1, accs[2]);
        issue(1'b1, 2'd3, 1'b0, 13'h008, 64'hA5A5_5A5A_1234_8765, 1'b0, accs[3]);
        for (int i = 1; i < 4; i++) chk("b2b_accept_cycle", 64'(accs[i] - accs[0]), 64'(2 * i));

        // Reset while the RMW write-back is pending.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 13'h011; req_wdata = 64'h55;
        #1;
        chk("rstrmw_ready", 64'(req_ready), 64'(1));
        chk("rstrmw_read",  64'(mem_read),  64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset_b = 1'b0;
        @(negedge clk); #1;
        chk("rstrmw_no_write", 64'(mem_write), 64'(0));
        chk("rstrmw_no_read",  64'(mem_read),  64'(0));
        chk("rstrmw_no_rsp",   64'(rsp_valid), 64'(0));
        @(posedge clk); #1;
        reset_b = 1'b1;
        @(negedge clk); #1;
        chk("rstrmw_ready_after", 64'(req_ready), 64'(1));
        chk("rstrmw_mem_kept", dmem[2], ref_mem[2]);
        issue(1'b0, 2'd3, 1'b0, 13'h010, 64'h0, 1'b0, acc);

        for (int n = 0; n < 250; n++) begin
            a  = 13'(($urandom_range(0, 7) << 3) | $urandom_range(0, 7));
            sz = 2'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)), acc);
        end

        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        for (int i = 0; i < 8; i++) chk("final_mem_word", dmem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting directly upstream of `dmem`: it accepts byte/half/word/doubleword load and store requests from the MEM pipeline stage and drives `dmem`'s 64-bit-wide port. Sub-doubleword stores are performed as read-modify-write over two cycles. Loads are sign-extended or zero-extended to 64 bits. Misaligned accesses are detected and suppressed.

## Interface
Parameters:
- `ADDR_W`, 13: byte-address width; dmem index = `req_addr[ADDR_W-1:3]` (10 bits).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_b`  in  1  reset; one clock, reset is synchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; equals (state==IDLE) && reset_b.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 dword.
- `req_unsigned`  in  1  load zero-extends when 1; ignored for stores and dword.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  64  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle response pulse, no backpressure.
- `rsp_rdata`  out  64  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned access, valid with `rsp_valid`.
- `mem_addr`  out  10  to dmem `addr`.
- `mem_din`  out  64  to dmem `din`.
- `mem_read`, `mem_write`  out  1 each  to dmem.
- `mem_dout`  in  64  from dmem; valid the cycle after `mem_read`.

## Operation
- Handshake: accept on `req_valid && req_ready`. Request fields are captured into registers on acceptance.
- States: IDLE, LOAD, RMW, RESP.
- IDLE, accept load: `mem_read`=1 combinationally that cycle; next state is LOAD.
- IDLE, accept dword store: `mem_write`=1, `mem_din`=`req_wdata`; next state is RESP.
- IDLE, accept sub-dword store: `mem_read`=1; next state is RMW.
- LOAD: extract the lane at byte offset `addr[2:0]` (little-endian) from `mem_dout`. Sign- or zero-extend it into the response registers. Next state is IDLE.
- RMW: merge the store data into `mem_dout` under the byte mask (size bytes starting at the offset). Drive `mem_write`=1 and `mem_addr` from the captured address. Next state is IDLE.
- RESP: next state is IDLE.
- Misalignment: the offset is not a multiple of the size. The block performs no memory access and goes to RESP with `rsp_err`=1.
- `mem_*` outputs are 0 whenever no access is issued. `mem_read` and `mem_write` are never high together.
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. All `mem_*` outputs are 0 while `reset_b`=0.
- Reset mid-operation: state returns to IDLE at the reset edge. A pending RMW write or response is dropped. No access is issued during the reset cycle.

## Timing
- Every request accepted in cycle N has `rsp_valid` in cycle N+1.
- `req_ready` returns high in N+2, so peak throughput is 1 request per 2 cycles.
- Dword store: written at N. Sub-dword store: written at N+1. The memory is visible to a load accepted at N+2.
- A `req_valid` held while `req_ready`=0 is not accepted and is not lost; the upstream stage holds it.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: misalignment detection and `rsp_err` behave as above.
- Not defined: offset bits below the access size are forced to 0 (natural alignment), every access proceeds, and `rsp_err` is tied to 0.

## Structure
- Shared package `lsu_pkg`:
  - `lsu_size_e` (BYTE, HALF, WORD, DWORD)
  - `lsu_state_e`
  - constant `DMEM_IDX_W`=10
- Sub-module `lsu_lane`: combinational byte-mask generation, store-data replication/merge, and load extract/extend. It is shared by the LOAD and RMW paths.

## Test plan
- Dword store, then load: store 0x0123_4567_89AB_CDEF at 0x010; load dword at 0x010 in N+2 -> `rsp_rdata`=0x0123_4567_89AB_CDEF, `rsp_err`=0.
- Byte RMW: after the above, store byte 0xFF at 0x013 -> `mem_read` at N, `mem_write` at N+1 with `mem_din`=0x0123_4567_FFAB_CDEF; other bytes unchanged.
- Extension: load signed byte at 0x013 -> 0xFFFF_FFFF_FFFF_FFFF. Load unsigned half at 0x012 -> 0x0000_0000_0000_FFAB.
- Misaligned: word load at 0x016 -> `rsp_valid`, `rsp_err`=1, `rsp_rdata`=0, no `mem_read`. Without the macro, it reads the word at 0x014.
- Back-to-back: `req_valid` held high for 4 requests -> accepted at N, N+2, N+4, N+6; `req_ready` low in N+1, N+3, N+5.
- Reset during RMW: `reset_b`=0 in cycle N+1 of a byte store -> no `mem_write`, `rsp_valid`=0, memory word unchanged, `req_ready`=1 in the first cycle after `reset_b` returns high.
